owire_rx: RTL and testbench

- Receive side of the single-wire half-duplex link whose transmit side drives the shared pad through an O_BUFT (data on I, tristate enable on T).
- Samples the pad value returned by the I_BUF, detects start bits, and deserialises LSB-first frames of the form start(0), DATA_W bits, [parity], stop(1).
- Presents each received word on a valid/ready handshake to fabric logic.
- Sits between the pad I_BUF output and the link controller.

---
 rtl/owire_rx.sv | 176 +++++++++++++++++
 tb/tb_owire_rx.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/owire_rx.sv
// owire_rx: single-wire link receiver with a 2-flop input synchroniser, mid-bit sampling and a valid/ready word output.
// Define OWIRE_RX_PARITY_EN to expect an even-parity bit after the data and to add the parity_err output.
module owire_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              frame_err,
  output logic              overrun,
`ifdef OWIRE_RX_PARITY_EN
  output logic              parity_err,
`endif
  output logic              busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] HALF     = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL     = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t            state, state_n;
  logic              sync1, s_din, prev_din;
  logic [CW-1:0]     cyc_cnt, cyc_n;
  logic [BW-1:0]     bit_cnt, bit_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic              word_done, stop_bad;
`ifdef OWIRE_RX_PARITY_EN
  logic              par_bad, par_bad_n, par_fail;
`endif

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= 1'b1;
      s_din    <= 1'b1;
      prev_din <= 1'b1;
      state    <= IDLE;
      cyc_cnt  <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
`ifdef OWIRE_RX_PARITY_EN
      par_bad  <= 1'b0;
`endif
    end else begin
      sync1    <= din;
      s_din    <= sync1;
      prev_din <= s_din;
      state    <= state_n;
      cyc_cnt  <= cyc_n;
      bit_cnt  <= bit_n;
      shreg    <= shreg_n;
`ifdef OWIRE_RX_PARITY_EN
      par_bad  <= par_bad_n;
`endif
    end
  end

  // Counters restart at 0 on every sample point so each bit is sampled mid-period.
  always_comb begin
    state_n   = state;
    cyc_n     = cyc_cnt + 1'b1;
    bit_n     = bit_cnt;
    shreg_n   = shreg;
    word_done = 1'b0;
    stop_bad  = 1'b0;
`ifdef OWIRE_RX_PARITY_EN
    par_bad_n = par_bad;
    par_fail  = 1'b0;
`endif
    case (state)
      IDLE: begin
        cyc_n = '0;
        if (prev_din && !s_din) state_n = START;
      end
      START: begin
        if (cyc_cnt == HALF) begin
          cyc_n   = '0;
          bit_n   = '0;
          state_n = s_din ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cyc_cnt == FULL) begin
          cyc_n               = '0;
          shreg_n             = shreg >> 1;
          shreg_n[DATA_W-1]   = s_din;
          bit_n               = bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) begin
            bit_n = '0;
`ifdef OWIRE_RX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end
      end
`ifdef OWIRE_RX_PARITY_EN
      PARITY: begin
        if (cyc_cnt == FULL) begin
          cyc_n     = '0;
          par_bad_n = (^shreg) ^ s_din;
          state_n   = STOP;
        end
      end
`endif
      STOP: begin
        if (cyc_cnt == FULL) begin
          cyc_n = '0;
          if (s_din) begin
            state_n = IDLE;
`ifdef OWIRE_RX_PARITY_EN
            word_done = !par_bad;
            par_fail  = par_bad;
`else
            word_done = 1'b1;
`endif
          end else begin
            stop_bad = 1'b1;
            state_n  = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        cyc_n = '0;
        if (s_din) state_n = IDLE;
      end
      default: begin
        cyc_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  // A finished word replaces the pending one only if that one is being accepted this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef OWIRE_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err <= stop_bad;
`ifdef OWIRE_RX_PARITY_EN
      parity_err <= par_fail;
`endif
      if (word_done && (!rx_valid || rx_ready)) begin
        rx_data  <= shreg;
        rx_valid <= 1'b1;
      end else begin
        if (word_done) overrun <= 1'b1;
        if (rx_valid && rx_ready) rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_owire_rx.sv
// tb_owire_rx: directed and randomized frames checked against a frame-level model of owire_rx.
// Honours OWIRE_RX_PARITY_EN to exercise the parity variant.
module tb_owire_rx;

  localparam int N      = 16;
  localparam int DATA_W = 8;
`ifdef OWIRE_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              din;
  logic              rx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid, frame_err, overrun, busy;
`ifdef OWIRE_RX_PARITY_EN
  logic              parity_err;
`endif

  owire_rx #(.CLKS_PER_BIT(N), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
`ifdef OWIRE_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;
  int ferr_cnt = 0;
  int perr_cnt = 0;
  int rise_cycle = -1;
  int fall_cycle = 0;
  int run = 0, max_run = 0;
  bit rand_ready = 1'b0;
  logic [DATA_W-1:0] got_q[$];
  logic [DATA_W-1:0] exp_q[$];
  int exp_ferr = 0, exp_perr = 0;
  logic              prev_valid = 1'b0, prev_xfer = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)", tag, observed, expected, cycle);
    end
  endtask

  always @(posedge clk) cycle <= cycle + 1;

  // Output monitor: collects accepted words and error pulses, and checks data holds while stalled.
  always @(negedge clk) begin
    if (rx_valid && rx_ready) got_q.push_back(rx_data);
    if (frame_err) ferr_cnt++;
`ifdef OWIRE_RX_PARITY_EN
    if (parity_err) perr_cnt++;
`endif
    if (rx_valid && !prev_valid) rise_cycle = cycle;
    run = rx_valid ? run + 1 : 0;
    if (run > max_run) max_run = run;
    if (prev_valid && !prev_xfer && rx_valid) checkOutput("stable", 32'(rx_data), 32'(prev_data));
    prev_valid = rx_valid;
    prev_xfer  = rx_valid && rx_ready;
    prev_data  = rx_data;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (rand_ready) rx_ready = 1'($urandom_range(0, 1));
    end
  endtask

  // Drives one frame; din is left at the stop-bit level afterwards.
  task automatic applyStimulus(input logic [DATA_W-1:0] data, input bit par_ok, input bit stop);
    fall_cycle = cycle;
    din = 1'b0;
    tick(N);
    for (int k = 0; k < DATA_W; k++) begin
      din = data[k];
      tick(N);
    end
    if (PAR_EN) begin
      din = (^data) ^ !par_ok;
      tick(N);
    end
    din = stop;
    tick(N);
  endtask

  // Frame-level reference: a frame yields a word only if its stop bit and parity are good.
  task automatic model_frame(input logic [DATA_W-1:0] data, input bit par_ok, input bit stop);
    if (!stop) exp_ferr++;
    else if (PAR_EN && !par_ok) exp_perr++;
    else exp_q.push_back(data);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] simulation timed out");
  end

  initial begin
    int lat, exp_lat, base_ferr, base_perr, nframes;
    logic [DATA_W-1:0] d;
    bit pok, stp;

    rst = 1'b1; din = 1'b1; rx_ready = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(100);
    checkOutput("reset_valid", 32'(rx_valid), 0);
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_ferr", 32'(frame_err), 0);
    checkOutput("reset_overrun", 32'(overrun), 0);
    checkOutput("reset_data", 32'(rx_data), 0);

    $display("[TB] single frame 0xA5");
    rx_ready = 1'b1; got_q.delete(); max_run = 0; ferr_cnt = 0;
    applyStimulus(8'hA5, 1'b1, 1'b1);
    tick(20);
    checkOutput("a5_count", got_q.size(), 1);
    if (got_q.size() > 0) checkOutput("a5_data", 32'(got_q[0]), 32'hA5);
    checkOutput("a5_valid_run", max_run, 1);
    checkOutput("a5_ferr", ferr_cnt, 0);
    checkOutput("a5_overrun", 32'(overrun), 0);
    lat = rise_cycle - fall_cycle;
    exp_lat = 3 + N / 2 + (DATA_W + 1 + (PAR_EN ? 1 : 0)) * N + 1;
    checkOutput("a5_latency", (lat >= exp_lat - 1 && lat <= exp_lat + 1) ? exp_lat : lat, exp_lat);

    $display("[TB] glitch rejection");
    got_q.delete();
    din = 1'b0;
    tick(5);
    checkOutput("glitch_busy_high", 32'(busy), 1);
    din = 1'b1;
    tick(20);
    checkOutput("glitch_busy_low", 32'(busy), 0);
    checkOutput("glitch_words", got_q.size(), 0);
    checkOutput("glitch_ferr", ferr_cnt, 0);

    $display("[TB] bad stop then break");
    applyStimulus(8'h3C, 1'b1, 1'b0);
    tick(40);
    checkOutput("break_busy", 32'(busy), 1);
    checkOutput("break_ferr", ferr_cnt, 1);
    checkOutput("break_words", got_q.size(), 0);
    din = 1'b1;
    tick(10);
    checkOutput("break_idle", 32'(busy), 0);
    checkOutput("break_ferr_once", ferr_cnt, 1);

`ifdef OWIRE_RX_PARITY_EN
    $display("[TB] parity checks");
    perr_cnt = 0; ferr_cnt = 0;
    applyStimulus(8'h07, 1'b0, 1'b1);
    tick(10);
    checkOutput("par_err_once", perr_cnt, 1);
    checkOutput("par_err_words", got_q.size(), 0);
    applyStimulus(8'h07, 1'b1, 1'b1);
    tick(10);
    checkOutput("par_ok_count", got_q.size(), 1);
    if (got_q.size() > 0) checkOutput("par_ok_data", 32'(got_q[0]), 32'h07);
    got_q.delete();
    applyStimulus(8'h07, 1'b0, 1'b0);
    din = 1'b1;
    tick(10);
    checkOutput("par_both_ferr", ferr_cnt, 1);
    checkOutput("par_both_perr", perr_cnt, 1);
`endif

    $display("[TB] overrun");
    rx_ready = 1'b0; got_q.delete();
    applyStimulus(8'h11, 1'b1, 1'b1);
    applyStimulus(8'h22, 1'b1, 1'b1);
    tick(10);
    checkOutput("ovr_valid", 32'(rx_valid), 1);
    checkOutput("ovr_data", 32'(rx_data), 32'h11);
    checkOutput("ovr_flag", 32'(overrun), 1);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    tick(3);
    checkOutput("ovr_accept_count", got_q.size(), 1);
    if (got_q.size() > 0) checkOutput("ovr_accept_data", 32'(got_q[0]), 32'h11);
    checkOutput("ovr_valid_drop", 32'(rx_valid), 0);
    checkOutput("ovr_sticky", 32'(overrun), 1);

    $display("[TB] reset during DATA");
    rx_ready = 1'b1; got_q.delete();
    din = 1'b0; tick(N);
    din = 1'b1; tick(N);
    din = 1'b0; tick(N);
    rst = 1'b1; din = 1'b1;
    tick(1);
    rst = 1'b0;
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_valid", 32'(rx_valid), 0);
    checkOutput("rst_overrun", 32'(overrun), 0);
    checkOutput("rst_data", 32'(rx_data), 0);
    tick(2 * N);
    checkOutput("rst_no_word", got_q.size(), 0);
    applyStimulus(8'h5A, 1'b1, 1'b1);
    tick(20);
    checkOutput("rst_5a_count", got_q.size(), 1);
    if (got_q.size() > 0) checkOutput("rst_5a_data", 32'(got_q[0]), 32'h5A);

    $display("[TB] randomized frames");
    got_q.delete(); exp_q.delete();
    exp_ferr = 0; exp_perr = 0;
    base_ferr = ferr_cnt; base_perr = perr_cnt;
    rand_ready = 1'b1;
    nframes = 25;
    for (int f = 0; f < nframes; f++) begin
      d   = DATA_W'($urandom);
      stp = ($urandom_range(0, 7) != 0);
      pok = PAR_EN ? ($urandom_range(0, 7) != 0) : 1'b1;
      model_frame(d, pok, stp);
      applyStimulus(d, pok, stp);
      din = 1'b1;
      tick(stp ? $urandom_range(0, 10) : N + $urandom_range(0, 10));
    end
    tick(60);
    rand_ready = 1'b0;
    rx_ready = 1'b1;
    tick(5);
    checkOutput("rand_count", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      checkOutput("rand_word", 32'(got_q[i]), 32'(exp_q[i]));
    checkOutput("rand_ferr", ferr_cnt - base_ferr, exp_ferr);
`ifdef OWIRE_RX_PARITY_EN
    checkOutput("rand_perr", perr_cnt - base_perr, exp_perr);
`endif
    checkOutput("rand_overrun", 32'(overrun), 0);
    checkOutput("rand_idle", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule
